// File: rtl/pipeline_controller.sv
// Stall/bubble controller for a 5-stage MIPS-style pipeline: load-use interlock,
// data-memory wait, fetch wait, plus stall statistics and a memory watchdog.
module pipeline_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_instr,
  input  logic        exe_GPR_we,
  input  logic [4:0]  exe_GPR_waddr,
  input  logic [1:0]  exe_GPR_wdata_select,
  input  logic        dmem_busy,
  input  logic        imem_ready,
  input  logic        stat_clr,
  output logic        pc_ena,
  output logic        if_id_ena,
  output logic        id_exe_ena,
  output logic        exe_mem_ena,
  output logic        mem_wb_ena,
  output logic        if_id_bubble,
  output logic        id_exe_bubble,
  output logic [15:0] stall_count,
  output logic        mem_timeout,
  output logic [1:0]  ctrl_state
);

  localparam logic [1:0] RUN        = 2'b00;
  localparam logic [1:0] LOAD_STALL = 2'b01;
  localparam logic [1:0] MEM_WAIT   = 2'b10;
  localparam logic [1:0] FETCH_WAIT = 2'b11;

  logic [1:0] state;
  logic [1:0] state_next;
  logic [7:0] wait_cnt;
  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rt_used;
  logic       load_use;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign opcode  = id_instr[31:26];
  assign rs      = id_instr[25:21];
  assign rt      = id_instr[20:16];
  assign rt_used = (opcode == 6'b000000) || (opcode == 6'b101011) ||
                   (opcode == 6'b000100) || (opcode == 6'b000101);

  assign load_use = exe_GPR_we && (exe_GPR_wdata_select == 2'b01) &&
                    (exe_GPR_waddr != 5'd0) &&
                    ((exe_GPR_waddr == rs) || (rt_used && (exe_GPR_waddr == rt)));

  // The interlock bubble already separates the load from its consumer, so
  // LOAD_STALL must not re-trigger on the same ID instruction.
  always_comb begin
    pc_ena        = 1'b1;
    if_id_ena     = 1'b1;
    id_exe_ena    = 1'b1;
    exe_mem_ena   = 1'b1;
    mem_wb_ena    = 1'b1;
    if_id_bubble  = 1'b0;
    id_exe_bubble = 1'b0;
    state_next    = RUN;
    if (dmem_busy) begin
      pc_ena      = 1'b0;
      if_id_ena   = 1'b0;
      id_exe_ena  = 1'b0;
      exe_mem_ena = 1'b0;
      mem_wb_ena  = 1'b0;
      state_next  = MEM_WAIT;
    end else if (load_use && (state != LOAD_STALL)) begin
      pc_ena        = 1'b0;
      if_id_ena     = 1'b0;
      id_exe_bubble = 1'b1;
      state_next    = LOAD_STALL;
    end else if (!imem_ready) begin
      pc_ena       = 1'b0;
      if_id_bubble = 1'b1;
      state_next   = FETCH_WAIT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= 16'd0;
    end else if (stat_clr) begin
      stall_count <= 16'd0;
    end else if (!pc_ena) begin
      stall_count <= sat_inc16(stall_count);
    end
  end

  // Watchdog: flag raises on the edge that brings the run of busy cycles to 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      wait_cnt <= dmem_busy ? sat_inc8(wait_cnt) : 8'd0;
      if (stat_clr) begin
        mem_timeout <= 1'b0;
      end else if (dmem_busy && (wait_cnt >= 8'd254)) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  assign ctrl_state = state;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller.
module tb_pipeline_controller;

  logic        clk;
  logic        reset;
  logic [31:0] id_instr;
  logic        exe_GPR_we;
  logic [4:0]  exe_GPR_waddr;
  logic [1:0]  exe_GPR_wdata_select;
  logic        dmem_busy;
  logic        imem_ready;
  logic        stat_clr;
  logic        pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena;
  logic        if_id_bubble, id_exe_bubble;
  logic [15:0] stall_count;
  logic        mem_timeout;
  logic [1:0]  ctrl_state;

  int checks = 0;
  int errors = 0;

  // {pc, if_id, id_exe, exe_mem, mem_wb, if_id_bubble, id_exe_bubble}
  localparam logic [6:0] EN_ALL   = 7'b1111100;
  localparam logic [6:0] EN_LU    = 7'b0011101;
  localparam logic [6:0] EN_MEM   = 7'b0000000;
  localparam logic [6:0] EN_FETCH = 7'b0111110;

  localparam logic [31:0] ADD_9_8_1  = 32'h01014820;
  localparam logic [31:0] ADD_9_1_8  = 32'h00284820;
  localparam logic [31:0] ADD_9_0_0  = 32'h00004820;
  localparam logic [31:0] ADDI_8_1_5 = 32'h20280005;
  localparam logic [31:0] SW_8_0_1   = 32'hAC280000;

  pipeline_controller dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .exe_GPR_we(exe_GPR_we),
    .exe_GPR_waddr(exe_GPR_waddr), .exe_GPR_wdata_select(exe_GPR_wdata_select),
    .dmem_busy(dmem_busy), .imem_ready(imem_ready), .stat_clr(stat_clr),
    .pc_ena(pc_ena), .if_id_ena(if_id_ena), .id_exe_ena(id_exe_ena),
    .exe_mem_ena(exe_mem_ena), .mem_wb_ena(mem_wb_ena),
    .if_id_bubble(if_id_bubble), .id_exe_bubble(id_exe_bubble),
    .stall_count(stall_count), .mem_timeout(mem_timeout), .ctrl_state(ctrl_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_en(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena,
              if_id_bubble, id_exe_bubble}, {25'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exe(input logic we, input logic [4:0] waddr, input logic [1:0] sel);
    exe_GPR_we = we;
    exe_GPR_waddr = waddr;
    exe_GPR_wdata_select = sel;
  endtask

  initial begin
    reset = 1'b0; id_instr = 32'd0; dmem_busy = 1'b0; imem_ready = 1'b1; stat_clr = 1'b0;
    set_exe(1'b0, 5'd0, 2'b00);
    tick(); tick();
    chk("reset_state", {30'd0, ctrl_state}, 32'd0);
    chk("reset_stall_count", {16'd0, stall_count}, 32'd0);
    chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    chk_en("reset_enables", EN_ALL);
    reset = 1'b1;
    tick();

    // lw to $0 never interlocks
    set_exe(1'b1, 5'd0, 2'b01); id_instr = ADD_9_0_0; #1;
    chk_en("zero_reg_no_stall", EN_ALL);
    tick();
    chk("zero_reg_count", {16'd0, stall_count}, 32'd0);

    // Classic load-use on rs
    set_exe(1'b1, 5'd8, 2'b01); id_instr = ADD_9_8_1; #1;
    chk_en("lu_rs_enables", EN_LU);
    chk("lu_rs_state_run", {30'd0, ctrl_state}, 32'd0);
    tick();
    chk("lu_state_loadstall", {30'd0, ctrl_state}, 32'd1);
    chk("lu_count1", {16'd0, stall_count}, 32'd1);
    #1;
    chk_en("loadstall_no_reeval", EN_ALL);
    tick();
    chk("lu_back_run", {30'd0, ctrl_state}, 32'd0);
    chk("lu_count_hold", {16'd0, stall_count}, 32'd1);

    // rt match: only for opcodes that read rt
    set_exe(1'b1, 5'd8, 2'b01); id_instr = ADDI_8_1_5; #1;
    chk_en("addi_rt_ignored", EN_ALL);
    id_instr = ADD_9_1_8; #1;
    chk_en("rtype_rt_stall", EN_LU);
    set_exe(1'b1, 5'd8, 2'b00); #1;
    chk_en("alu_src_no_stall", EN_ALL);
    set_exe(1'b0, 5'd8, 2'b01); #1;
    chk_en("we0_no_stall", EN_ALL);
    tick();
    set_exe(1'b1, 5'd8, 2'b01); id_instr = SW_8_0_1; #1;
    chk_en("sw_rt_stall", EN_LU);
    tick();
    set_exe(1'b0, 5'd0, 2'b00);
    tick();
    chk("sw_count", {16'd0, stall_count}, 32'd2);

    // dmem_busy during load-use: 3 frozen cycles, then the bubble
    set_exe(1'b1, 5'd8, 2'b01); id_instr = ADD_9_8_1; dmem_busy = 1'b1; imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_en("busy_freeze", EN_MEM);
      tick();
      chk("busy_state", {30'd0, ctrl_state}, 32'd2);
    end
    dmem_busy = 1'b0; imem_ready = 1'b1; #1;
    chk_en("memwait_exit_lu", EN_LU);
    tick();
    chk("memwait_to_loadstall", {30'd0, ctrl_state}, 32'd1);
    set_exe(1'b0, 5'd0, 2'b00);
    tick();
    chk("busy_lu_count", {16'd0, stall_count}, 32'd6);

    // Fetch wait for two cycles
    imem_ready = 1'b0; #1;
    chk_en("fetch_wait1", EN_FETCH);
    tick();
    chk("fetch_state", {30'd0, ctrl_state}, 32'd3);
    chk_en("fetch_wait2", EN_FETCH);
    tick();
    imem_ready = 1'b1; #1;
    chk_en("fetch_exit", EN_ALL);
    tick();
    chk("fetch_to_run", {30'd0, ctrl_state}, 32'd0);
    chk("fetch_count", {16'd0, stall_count}, 32'd8);

    // stat_clr beats increment in the same cycle; FSM unaffected
    imem_ready = 1'b0; stat_clr = 1'b1;
    tick();
    chk("clr_priority", {16'd0, stall_count}, 32'd0);
    chk("clr_fsm_kept", {30'd0, ctrl_state}, 32'd3);
    imem_ready = 1'b1; stat_clr = 1'b0;
    tick();

    // Watchdog: 300 busy cycles
    dmem_busy = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) chk("timeout_not_yet", {31'd0, mem_timeout}, 32'd0);
      if (i == 255) chk("timeout_at_255", {31'd0, mem_timeout}, 32'd1);
    end
    chk("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
    chk("count_300", {16'd0, stall_count}, 32'd300);
    dmem_busy = 1'b0;
    tick();
    chk("timeout_after_busy", {31'd0, mem_timeout}, 32'd1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("timeout_cleared", {31'd0, mem_timeout}, 32'd0);
    chk("count_cleared", {16'd0, stall_count}, 32'd0);

    // Saturation of stall_count
    dmem_busy = 1'b1;
    for (int i = 1; i <= 65537; i++) begin
      tick();
      if (i == 65534) chk("count_fffe", {16'd0, stall_count}, 32'h0000FFFE);
      if (i == 65535) chk("count_ffff", {16'd0, stall_count}, 32'h0000FFFF);
    end
    chk("count_saturated", {16'd0, stall_count}, 32'h0000FFFF);
    chk("sat_state_memwait", {30'd0, ctrl_state}, 32'd2);

    // Reset mid-MEM_WAIT
    #2;
    reset = 1'b0; #1;
    chk("midreset_state", {30'd0, ctrl_state}, 32'd0);
    chk("midreset_count", {16'd0, stall_count}, 32'd0);
    chk("midreset_timeout", {31'd0, mem_timeout}, 32'd0);
    chk_en("midreset_comb_busy", EN_MEM);
    dmem_busy = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_state", {30'd0, ctrl_state}, 32'd0);
    chk("post_reset_count", {16'd0, stall_count}, 32'd0);
    chk_en("post_reset_enables", EN_ALL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have port: clk  input  1  single pipeline clock, all state updates on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; state cleared while low.
REQ-003 SHALL have port: id_instr  input  32  instruction currently in ID.
REQ-004 SHALL have port: exe_GPR_we  input  1  EXE-stage register write enable.
REQ-005 SHALL have port: exe_GPR_waddr  input  5  EXE-stage destination register.
REQ-006 SHALL have port: exe_GPR_wdata_select  input  2  EXE-stage writeback source; 2'b01 = memory load.
REQ-007 SHALL have port: dmem_busy  input  1  data memory not ready this cycle.
REQ-008 SHALL have port: imem_ready  input  1  instruction memory returned a valid fetch this cycle.
REQ-009 SHALL have port: stat_clr  input  1  synchronous clear of stall counter and timeout flag.
REQ-010 SHALL have outputs, 1 bit each: pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena (stage register enables); if_id_bubble (IF/ID loads a NOP); id_exe_bubble (ID/EXE loads a NOP, exe_GPR_we forced 0).
REQ-011 SHALL have outputs: stall_count  16  saturating stall-cycle counter; mem_timeout  1  sticky watchdog flag; ctrl_state  2  current FSM state.

Function
REQ-012 SHALL decode rs = id_instr[25:21], rt = id_instr[20:16]; rt used iff opcode (id_instr[31:26]) is 000000, 101011 (sw), 000100 (beq) or 000101 (bne).
REQ-013 SHALL flag load_use = exe_GPR_we & (exe_GPR_wdata_select == 2'b01) & (exe_GPR_waddr != 0) & (exe_GPR_waddr == rs | (rt_used & exe_GPR_waddr == rt)).
REQ-014 SHALL implement FSM states RUN=2'b00, LOAD_STALL=2'b01, MEM_WAIT=2'b10, FETCH_WAIT=2'b11, presented on ctrl_state.
REQ-015 SHALL evaluate conditions in priority order each cycle: dmem_busy > load_use (RUN only) > !imem_ready > none; outputs combinational from state and inputs.
REQ-016 dmem_busy=1 (any state): all five enables 0, both bubbles 0; next state MEM_WAIT.
REQ-017 load_use=1 in RUN, dmem_busy=0: pc_ena=0, if_id_ena=0, id_exe_ena=1, id_exe_bubble=1, exe_mem_ena=1, mem_wb_ena=1; next state LOAD_STALL.
REQ-018 LOAD_STALL SHALL last exactly one cycle; load_use is not re-evaluated there; with dmem_busy=0 enables all 1 and next state RUN (or FETCH_WAIT if imem_ready=0).
REQ-019 imem_ready=0, higher conditions absent: pc_ena=0, if_id_ena=1, if_id_bubble=1, remaining enables 1; next state FETCH_WAIT.
REQ-020 No condition active: all enables 1, bubbles 0; next state RUN.
REQ-021 MEM_WAIT exits on first cycle with dmem_busy=0, applying REQ-017..REQ-020 that same cycle.
REQ-022 stall_count SHALL increment by 1 on every cycle with pc_ena=0, saturate at 16'hFFFF, never wrap.
REQ-023 SHALL keep an 8-bit wait counter: incremented each consecutive dmem_busy cycle, cleared when dmem_busy=0; on reaching 255 mem_timeout sets and stays 1.
REQ-024 stat_clr=1 SHALL zero stall_count and mem_timeout next edge, taking priority over increment/set in the same cycle; FSM unaffected.

Reset
REQ-025 While reset=0: state RUN, stall_count 0, wait counter 0, mem_timeout 0; enables then follow REQ-015 combinationally.
REQ-026 Reset asserted mid-stall SHALL abandon the stall immediately; no stall cycle is counted after release unless a condition recurs.

Verification
REQ-027 EXE lw to $8, ID add $9,$8,$1 -> one cycle pc_ena=0, if_id_ena=0, id_exe_bubble=1; then RUN; stall_count=1.
REQ-028 EXE lw to $0, ID uses $0 -> no stall, all enables 1, stall_count=0.
REQ-029 dmem_busy high 3 cycles during a load-use -> 3 cycles all enables 0 (state MEM_WAIT), then 1 load-use bubble cycle; stall_count=4.
REQ-030 imem_ready low 2 cycles -> pc_ena=0, if_id_bubble=1 for 2 cycles, state FETCH_WAIT, then RUN.
REQ-031 dmem_busy held 300 cycles -> mem_timeout=1 at cycle 255 and remains; stat_clr pulse -> mem_timeout=0, stall_count=0.
REQ-032 stall_count preloaded to 16'hFFFF via sustained stall -> further stalls keep 16'hFFFF; reset low mid-MEM_WAIT -> state RUN, counters 0.
